// File: rtl/pwm_cfg_pkg.sv
// Shared types and constants for the PWM configuration master.
package pwm_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_PER  = 3'd1,
        WR_DUTY = 3'd2,
        RD_PER  = 3'd3,
        RD_DUTY = 3'd4,
        FIN     = 3'd5
    } state_t;

    localparam int DEF_PERIOD_ADDR = 0;
    localparam int DEF_DUTY_ADDR   = 1;

    // A duty longer than the period is meaningless for the PWM, so saturate it.
    function automatic logic [31:0] clamp_duty(input logic [31:0] period, input logic [31:0] duty);
        return (duty > period) ? period : duty;
    endfunction

endpackage

// File: rtl/pwm_cfg_wait_timer.sv
// Counts consecutive stall cycles of one bus transaction; expired marks the WAIT_MAX-th stall.
module pwm_cfg_wait_timer #(
    parameter int WAIT_MAX = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic stall,
    output logic expired
);
    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    logic [CNT_W-1:0] count_reg;

    assign expired = stall && (count_reg == CNT_W'(WAIT_MAX - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (stall) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_cfg_master.sv
// Avalon-MM master that writes a period/duty pair to a PWM slave.
// Define PWM_CFG_READBACK_EN to add a read-back-and-compare of both registers.
module pwm_cfg_master
    import pwm_cfg_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int PERIOD_ADDR = DEF_PERIOD_ADDR,
    parameter int DUTY_ADDR   = DEF_DUTY_ADDR,
    parameter int WAIT_MAX    = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [31:0]       period,
    input  logic [31:0]       duty,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic              avm_read,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest
);
    state_t      state_reg;
    state_t      state_next;
    logic [31:0] period_reg;
    logic [31:0] duty_reg;
    logic        error_reg;
    logic        load;
    logic        abort;
    logic        in_xfer;
    logic        stall;
    logic        expired;

    assign in_xfer = (state_reg == WR_PER) || (state_reg == WR_DUTY) ||
                     (state_reg == RD_PER) || (state_reg == RD_DUTY);
    assign stall   = in_xfer && avm_waitrequest;
    assign error   = error_reg;

    pwm_cfg_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!stall),
        .stall   (stall),
        .expired (expired)
    );

`ifndef PWM_CFG_READBACK_EN
    logic [31:0] unused_readdata;
    assign unused_readdata = avm_readdata;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        load          = 1'b0;
        abort         = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        avm_address   = '0;
        avm_write     = 1'b0;
        avm_read      = 1'b0;
        avm_writedata = '0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = WR_PER;
                end
            end
            WR_PER: begin
                busy          = 1'b1;
                avm_write     = 1'b1;
                avm_address   = ADDR_W'(PERIOD_ADDR);
                avm_writedata = period_reg;
                if (expired) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (!avm_waitrequest) begin
                    state_next = WR_DUTY;
                end
            end
            WR_DUTY: begin
                busy          = 1'b1;
                avm_write     = 1'b1;
                avm_address   = ADDR_W'(DUTY_ADDR);
                avm_writedata = duty_reg;
                if (expired) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (!avm_waitrequest) begin
`ifdef PWM_CFG_READBACK_EN
                    state_next = RD_PER;
`else
                    state_next = FIN;
`endif
                end
            end
`ifdef PWM_CFG_READBACK_EN
            RD_PER: begin
                busy        = 1'b1;
                avm_read    = 1'b1;
                avm_address = ADDR_W'(PERIOD_ADDR);
                if (expired || (!avm_waitrequest && (avm_readdata != period_reg))) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (!avm_waitrequest) begin
                    state_next = RD_DUTY;
                end
            end
            RD_DUTY: begin
                busy        = 1'b1;
                avm_read    = 1'b1;
                avm_address = ADDR_W'(DUTY_ADDR);
                if (expired || (!avm_waitrequest && (avm_readdata != duty_reg))) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (!avm_waitrequest) begin
                    state_next = FIN;
                end
            end
`endif
            FIN: begin
                busy = 1'b1;
                done = 1'b1;
                // The FSM is back to accepting work in the same cycle done pulses.
                if (start) begin
                    load       = 1'b1;
                    state_next = WR_PER;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Error is registered so it lands in IDLE, where a new start is already accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_reg <= '0;
            duty_reg   <= '0;
            error_reg  <= 1'b0;
        end else begin
            error_reg <= abort;
            if (load) begin
                period_reg <= period;
                duty_reg   <= clamp_duty(period, duty);
            end
        end
    end

endmodule

// File: tb/tb_pwm_cfg_master.sv
// Directed, table-driven bench for pwm_cfg_master with a behavioural Avalon-MM slave.
module tb_pwm_cfg_master;

`ifdef PWM_CFG_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] period;
    logic [31:0] duty;
    logic        busy;
    logic        done;
    logic        error;
    logic [3:0]  avm_address;
    logic        avm_write;
    logic        avm_read;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    int checks   = 0;
    int failures = 0;

    pwm_cfg_master dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .period          (period),
        .duty            (duty),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_read        (avm_read),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] p;
        logic [31:0] d;
        int          stalls;
        logic        bad;
        logic [31:0] exp_wp;
        logic [31:0] exp_wd;
        int          exp_busy;
        int          exp_lat;
        int          exp_done;
        int          exp_err;
        int          exp_reads;
    } vec_t;

    vec_t vecs[$];

    // Results of the most recent run_xfer
    logic [31:0] r_wp, r_wd;
    int r_busy, r_done, r_err, r_reads, r_stalls, r_unstable, r_overlap, r_lat, r_strobe_at_err;
    logic r_ended;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Issues a start (immediately when pre is set, else on the next negedge) and plays the slave.
    task automatic run_xfer(input logic [31:0] p, input logic [31:0] d, input int stalls,
                            input logic [31:0] rd_per_val, input bit pre, input bit poke);
        int st = 0;
        bit in_tx = 0;
        int first = -1;
        int done_cyc = -1;
        logic [3:0]  snap_a = '0;
        logic [31:0] snap_d = '0;
        logic        snap_w = 1'b0;
        r_wp = 32'hDEADBEEF; r_wd = 32'hDEADBEEF;
        r_busy = 0; r_done = 0; r_err = 0; r_reads = 0; r_stalls = 0;
        r_unstable = 0; r_overlap = 0; r_lat = -1; r_strobe_at_err = -1; r_ended = 1'b0;
        if (!pre) @(negedge clk);
        start = 1'b1; period = p; duty = d;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (busy) begin
                r_busy++;
                if (first < 0) first = cyc;
            end
            if (avm_write && avm_read) r_overlap++;
            if (avm_write || avm_read) begin
                if (!in_tx) begin
                    in_tx = 1; st = stalls;
                    snap_a = avm_address; snap_d = avm_writedata; snap_w = avm_write;
                end else if (avm_address != snap_a || avm_writedata != snap_d || avm_write != snap_w) begin
                    r_unstable++;
                end
                if (st > 0) begin
                    avm_waitrequest = 1'b1; st--; r_stalls++;
                end else begin
                    avm_waitrequest = 1'b0; in_tx = 0;
                    if (avm_write) begin
                        if (avm_address == 4'd0) r_wp = avm_writedata; else r_wd = avm_writedata;
                    end else begin
                        r_reads++;
                        avm_readdata = (avm_address == 4'd0) ? rd_per_val : r_wd;
                    end
                end
            end else begin
                avm_waitrequest = 1'b0;
            end
            if (poke && cyc == 1) begin
                start = 1'b1; period = 32'd7; duty = 32'd3;
            end else begin
                start = 1'b0;
            end
            if (done) begin r_done++; done_cyc = cyc; end
            if (error) begin r_err++; r_strobe_at_err = int'(avm_write | avm_read); end
            if (done || error) begin
                r_ended = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (done_cyc >= 0 && first >= 0) r_lat = done_cyc - first;
        avm_waitrequest = 1'b0;
    endtask

    initial begin
        int n;
        reset_n = 1'b0; start = 1'b0; period = '0; duty = '0;
        avm_readdata = '0; avm_waitrequest = 1'b0;

        vecs.push_back('{32'd1000, 32'd250, 0, 1'b0, 32'd1000, 32'd250, 3 + 2*RB, 2 + 2*RB, 1, 0, 2*RB});
        vecs.push_back('{32'd1000, 32'd250, 3, 1'b0, 32'd1000, 32'd250, 9 + 8*RB, 8 + 8*RB, 1, 0, 2*RB});
        vecs.push_back('{32'd100,  32'd150, 0, 1'b0, 32'd100,  32'd100, 3 + 2*RB, 2 + 2*RB, 1, 0, 2*RB});
        vecs.push_back('{32'd50,   32'd50,  1, 1'b0, 32'd50,   32'd50,  5 + 4*RB, 4 + 4*RB, 1, 0, 2*RB});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFE, 2, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, 7 + 6*RB, 6 + 6*RB, 1, 0, 2*RB});
        if (RB == 1)
            vecs.push_back('{32'd1000, 32'd250, 0, 1'b1, 32'd1000, 32'd250, 3, -1, 0, 1, 1});

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_write", avm_write, 0);
        chk("rst_read", avm_read, 0);
        chk("rst_addr", avm_address, 0);
        chk("rst_wdata", avm_writedata, 0);
        reset_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_xfer(vecs[i].p, vecs[i].d, vecs[i].stalls,
                     vecs[i].bad ? 32'd999 : vecs[i].p, 1'b0, 1'b0);
            $display("vec %0d p=%0d d=%0d stalls=%0d -> wp=%0d wd=%0d busy=%0d lat=%0d done=%0d err=%0d reads=%0d",
                     i, vecs[i].p, vecs[i].d, vecs[i].stalls, r_wp, r_wd, r_busy, r_lat, r_done, r_err, r_reads);
            chk($sformatf("v%0d_ended", i), r_ended, 1);
            chk($sformatf("v%0d_wr_period", i), r_wp, vecs[i].exp_wp);
            chk($sformatf("v%0d_wr_duty", i), r_wd, vecs[i].exp_wd);
            chk($sformatf("v%0d_busy_cycles", i), r_busy, vecs[i].exp_busy);
            chk($sformatf("v%0d_done", i), r_done, vecs[i].exp_done);
            chk($sformatf("v%0d_error", i), r_err, vecs[i].exp_err);
            chk($sformatf("v%0d_reads", i), r_reads, vecs[i].exp_reads);
            chk($sformatf("v%0d_stable", i), r_unstable, 0);
            chk($sformatf("v%0d_overlap", i), r_overlap, 0);
            if (vecs[i].exp_lat >= 0)
                chk($sformatf("v%0d_latency", i), r_lat, vecs[i].exp_lat);
            @(negedge clk);
        end

        // Start while busy is ignored
        run_xfer(32'd400, 32'd40, 3, 32'd400, 1'b0, 1'b1);
        $display("poke: wp=%0d wd=%0d done=%0d", r_wp, r_wd, r_done);
        chk("poke_wr_period", r_wp, 400);
        chk("poke_wr_duty", r_wd, 40);
        chk("poke_done", r_done, 1);
        @(negedge clk);
        chk("poke_no_second_busy", busy, 0);

        // Start in the done cycle is accepted
        run_xfer(32'd1000, 32'd250, 0, 32'd1000, 1'b0, 1'b0);
        run_xfer(32'd300, 32'd30, 0, 32'd300, 1'b1, 1'b0);
        $display("chain_done: wp=%0d wd=%0d done=%0d", r_wp, r_wd, r_done);
        chk("chain_done_wp", r_wp, 300);
        chk("chain_done_wd", r_wd, 30);
        chk("chain_done_done", r_done, 1);
        @(negedge clk);

        // Timeout with waitrequest stuck high
        run_xfer(32'd1000, 32'd250, 100000, 32'd1000, 1'b0, 1'b0);
        $display("timeout: stalls=%0d err=%0d done=%0d strobe=%0d", r_stalls, r_err, r_done, r_strobe_at_err);
        chk("to_ended", r_ended, 1);
        chk("to_stall_cycles", r_stalls, 255);
        chk("to_error", r_err, 1);
        chk("to_done", r_done, 0);
        chk("to_strobe_dropped", r_strobe_at_err, 0);
        // Start in the error cycle is accepted
        run_xfer(32'd600, 32'd700, 0, 32'd600, 1'b1, 1'b0);
        $display("chain_err: wp=%0d wd=%0d done=%0d", r_wp, r_wd, r_done);
        chk("chain_err_done", r_done, 1);
        chk("chain_err_wd", r_wd, 600);
        @(negedge clk);

        // Reset during WR_DUTY stall
        start = 1'b1; period = 32'd500; duty = 32'd60;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        avm_waitrequest = 1'b1;
        @(negedge clk);
        chk("mid_in_wr_duty", avm_address, 1);
        #2 reset_n = 1'b0;
        #1;
        $display("mid_reset: write=%0d busy=%0d addr=%0d wdata=%0d", avm_write, busy, avm_address, avm_writedata);
        chk("mid_rst_write", avm_write, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", avm_address, 0);
        chk("mid_rst_wdata", avm_writedata, 0);
        @(negedge clk);
        reset_n = 1'b1;
        avm_waitrequest = 1'b0;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || error) n++;
        end
        chk("mid_rst_no_pulse", n, 0);
        run_xfer(32'd800, 32'd80, 1, 32'd800, 1'b0, 1'b0);
        $display("after_reset: wp=%0d wd=%0d done=%0d", r_wp, r_wd, r_done);
        chk("post_rst_done", r_done, 1);
        chk("post_rst_wp", r_wp, 800);
        chk("post_rst_wd", r_wd, 80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
